// File: rtl/lag_peak_finder_if.sv
// Sample-in / peak-lag-out bus of lag_peak_finder.
// The master drives correlation samples; the slave returns the packed peak lags.
interface lag_peak_finder_if #(
  parameter int CORR_BITS = 32,
  parameter int OUT_W     = 24
);
  logic signed [CORR_BITS-1:0] corrIn;
  logic                        corrInValid;
  logic                        corrInStart;
  logic                        corrInReady;
  logic [OUT_W-1:0]            dataOut;
  logic                        dataOutValid;

  modport master (
    output corrIn, corrInValid, corrInStart,
    input  corrInReady, dataOut, dataOutValid
  );

  modport slave (
    input  corrIn, corrInValid, corrInStart,
    output corrInReady, dataOut, dataOutValid
  );
endinterface

// File: rtl/lag_peak_finder.sv
// Per-channel argmax over a channel-major correlation frame; commits all peak lags at once.
// Optional macro LAG_PEAK_FINDER_ABS_EN ranks samples by saturated magnitude instead of signed value.
module lag_peak_finder #(
  parameter int NUM_SLAVES = 4,
  parameter int MAX_LAGS   = 17,
  parameter int CORR_BITS  = 32
) (
  input  logic             clk,
  input  logic             rst,
  lag_peak_finder_if.slave bus
);
  localparam int LAG_BITS = $clog2(2*MAX_LAGS);
  localparam int NUM_LAGS = 2*MAX_LAGS - 1;
  localparam int CH_BITS  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int OUT_W    = NUM_SLAVES * LAG_BITS;
  localparam logic [LAG_BITS-1:0] LAST_LAG = LAG_BITS'(NUM_LAGS - 1);
  localparam logic [CH_BITS-1:0]  LAST_CH  = CH_BITS'(NUM_SLAVES - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT} state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [LAG_BITS-1:0]         r_lag;
  logic [CH_BITS-1:0]          r_ch;
  logic signed [CORR_BITS-1:0] r_max;
  logic [LAG_BITS-1:0]         r_arg;
  logic [LAG_BITS-1:0]         r_work [NUM_SLAVES];
  logic [OUT_W-1:0]            r_dout;
  logic                        r_dvalid;

  logic                        w_ready;
  logic                        w_accept;
  logic                        w_start;
  logic                        w_take;
  logic [LAG_BITS-1:0]         w_lag;
  logic [CH_BITS-1:0]          w_ch;
  logic signed [CORR_BITS-1:0] w_key;
  logic                        w_better;
  logic [LAG_BITS-1:0]         w_arg;
  logic                        w_last_lag;
  logic                        w_frame_end;
  logic [OUT_W-1:0]            w_work_packed;

`ifdef LAG_PEAK_FINDER_ABS_EN
  // |most-negative| has no positive twin, so it clips to the largest positive value.
  function automatic logic signed [CORR_BITS-1:0] abs_sat(input logic signed [CORR_BITS-1:0] x);
    if (x == {1'b1, {(CORR_BITS-1){1'b0}}})
      return {1'b0, {(CORR_BITS-1){1'b1}}};
    else if (x < 0)
      return -x;
    else
      return x;
  endfunction

  assign w_key = abs_sat(bus.corrIn);
`else
  assign w_key = bus.corrIn;
`endif

  assign w_ready  = (r_state != COMMIT);
  assign w_accept = bus.corrInValid && w_ready;
  assign w_start  = w_accept && bus.corrInStart;
  assign w_take   = w_start || (w_accept && (r_state == ACCUM));

  // A start sample always counts as channel 0, lag 0, whatever the counters say.
  assign w_lag       = w_start ? '0 : r_lag;
  assign w_ch        = w_start ? '0 : r_ch;
  assign w_better    = (w_lag == '0) || (w_key > r_max);
  assign w_arg       = w_better ? w_lag : r_arg;
  assign w_last_lag  = (w_lag == LAST_LAG);
  assign w_frame_end = w_take && w_last_lag && (w_ch == LAST_CH);

  always_comb begin
    w_work_packed = '0;
    for (int k = 0; k < NUM_SLAVES; k++)
      w_work_packed[k*LAG_BITS +: LAG_BITS] = r_work[k];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = ACCUM;
      ACCUM:   if (w_frame_end) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---- accumulate stage: counters, running max/argmax, working lags ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lag    <= '0;
      r_ch     <= '0;
      r_max    <= '0;
      r_arg    <= '0;
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) r_work[k] <= '0;
    end else begin
      if (w_take) begin
        if (w_better) r_max <= w_key;
        r_arg <= w_arg;
        if (w_start)
          for (int k = 0; k < NUM_SLAVES; k++) r_work[k] <= '0;
        if (w_last_lag) begin
          r_lag        <= '0;
          r_ch         <= w_ch + 1'b1;
          r_work[w_ch] <= w_arg;
        end else begin
          r_lag <= w_lag + 1'b1;
          r_ch  <= w_ch;
        end
      end
      // ---- commit stage: publish the whole frame in one edge ----
      if (r_state == COMMIT) begin
        r_dout   <= w_work_packed;
        r_dvalid <= 1'b1;
      end
    end
  end

  assign bus.corrInReady  = w_ready;
  assign bus.dataOut      = r_dout;
  assign bus.dataOutValid = r_dvalid;
endmodule

// File: tb/tb_lag_peak_finder.sv
// Directed-plus-random bench for lag_peak_finder against a frame-level argmax model.
// Honours LAG_PEAK_FINDER_ABS_EN in the model the same way the design does.
module tb_lag_peak_finder;
  localparam int NS  = 4;
  localparam int ML  = 17;
  localparam int CB  = 32;
  localparam int LB  = 6;
  localparam int NL  = 2*ML - 1;
  localparam int TOT = NS * NL;
  localparam int OW  = NS * LB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lag_peak_finder_if #(.CORR_BITS(CB), .OUT_W(OW)) bus ();

  lag_peak_finder #(.NUM_SLAVES(NS), .MAX_LAGS(ML), .CORR_BITS(CB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic signed [CB-1:0] fr [TOT];
  logic [OW-1:0] last_commit;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ranking key of a sample, as a plain integer.
  function automatic longint key(input logic signed [CB-1:0] x);
    longint v;
    v = longint'(x);
`ifdef LAG_PEAK_FINDER_ABS_EN
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
`endif
    return v;
  endfunction

  // Earliest lag holding the largest key, per channel.
  function automatic logic [OW-1:0] model();
    logic [OW-1:0] r;
    int best;
    r = '0;
    for (int ch = 0; ch < NS; ch++) begin
      best = 0;
      for (int l = 1; l < NL; l++)
        if (key(fr[ch*NL + l]) > key(fr[ch*NL + best])) best = l;
      r[ch*LB +: LB] = LB'(best);
    end
    return r;
  endfunction

  task automatic idle_cycle();
    bus.corrInValid = 1'b0;
    bus.corrInStart = 1'($urandom_range(0, 1));
    bus.corrIn      = $signed($urandom);
    @(posedge clk); #1;
  endtask

  task automatic put(input logic signed [CB-1:0] d, input logic s, input bit gaps);
    int n;
    if (gaps) while ($urandom_range(0, 99) < 30) idle_cycle();
    bus.corrIn      = d;
    bus.corrInStart = s;
    bus.corrInValid = 1'b1;
    n = 0;
    while (!bus.corrInReady && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 10) check("ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    bus.corrInValid = 1'b0;
    bus.corrInStart = 1'b0;
  endtask

  task automatic send_frame(input bit gaps, input string tag);
    logic [OW-1:0] exp;
    for (int i = 0; i < TOT; i++) put(fr[i], (i == 0), gaps);
    exp = model();
    check({tag, "_ready_in_commit"}, 64'(bus.corrInReady), 64'd0);
    check({tag, "_hold_in_commit"}, 64'(bus.dataOut), 64'(last_commit));
    @(posedge clk); #1;
    check({tag, "_dout"}, 64'(bus.dataOut), 64'(exp));
    check({tag, "_valid"}, 64'(bus.dataOutValid), 64'd1);
    check({tag, "_ready_after"}, 64'(bus.corrInReady), 64'd1);
    last_commit = exp;
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int i = 0; i < TOT; i++) fr[i] = CB'($urandom_range(0, hi - lo) + lo);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.corrIn      = '0;
    bus.corrInValid = 1'b0;
    bus.corrInStart = 1'b0;
    rst             = 1'b0;
    last_commit     = '0;
    #12;
    check("rst_dout",  64'(bus.dataOut), 64'd0);
    check("rst_valid", 64'(bus.dataOutValid), 64'd0);
    check("rst_ready", 64'(bus.corrInReady), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Single peak per channel at lag 4k+2
    for (int i = 0; i < TOT; i++) fr[i] = '0;
    for (int k = 0; k < NS; k++) fr[k*NL + 4*k + 2] = 32'sd1000;
    send_frame(1'b0, "peak");
    check("peak_const", 64'(bus.dataOut), 64'h38A182);
    send_frame(1'b1, "peak_gaps");
    check("peak_gaps_const", 64'(bus.dataOut), 64'h38A182);

    // Ties keep the earliest lag
    for (int i = 0; i < TOT; i++) fr[i] = -32'sd5;
    fr[5] = 32'sd77;
    fr[20] = 32'sd77;
    for (int l = 0; l < NL; l++) fr[NL + l] = 32'sd9;
    send_frame(1'b0, "ties");
    check("ties_ch0", 64'(bus.dataOut[5:0]), 64'd5);
    check("ties_ch1", 64'(bus.dataOut[11:6]), 64'd0);

    // Negative curve on ch1, most-negative sample on ch2 lag 7
    fill_random(-1000, 1000);
    for (int l = 0; l < NL; l++) fr[NL + l] = CB'($urandom_range(0, 996) - 1000);
    fr[NL + 30] = -32'sd3;
    for (int l = 0; l < NL; l++) fr[2*NL + l] = CB'($urandom_range(0, 200) - 100);
    fr[2*NL + 7] = 32'sh8000_0000;
    send_frame(1'b1, "neg");
`ifdef LAG_PEAK_FINDER_ABS_EN
    check("neg_abs_ch2", 64'(bus.dataOut[17:12]), 64'd7);
`else
    check("neg_ch1", 64'(bus.dataOut[11:6]), 64'd30);
`endif

    // Abort: partial frame restarted by a new start sample
    for (int i = 0; i < TOT; i++) fr[i] = '0;
    fr[4] = 32'sd500;
    fr[NL + 3] = 32'sd500;
    fr[2*NL + 2] = 32'sd500;
    fr[3*NL + 2] = 32'sd500;
    send_frame(1'b0, "abort_f1");
    check("abort_f1_const", 64'(bus.dataOut), 64'h0820C4);
    fill_random(-50000, 50000);
    for (int i = 0; i < 50; i++) put(fr[i], (i == 0), 1'b1);
    check("abort_partial_dout", 64'(bus.dataOut), 64'h0820C4);
    check("abort_partial_valid", 64'(bus.dataOutValid), 64'd1);
    fill_random(-50000, 50000);
    send_frame(1'b1, "abort_f2");

    // Samples without a start in IDLE are ignored
    for (int i = 0; i < 10; i++) put(32'sd2000000000, 1'b0, 1'b0);
    fill_random(-300, 300);
    send_frame(1'b0, "idle_discard");

    // Random frames, small range to force ties
    for (int f = 0; f < 3; f++) begin
      fill_random(-4, 3);
      send_frame(1'b1, "rand_small");
    end
    for (int i = 0; i < TOT; i++) fr[i] = $signed($urandom);
    send_frame(1'b1, "rand_full");

    // Reset mid-frame discards it; next frame commits normally
    fill_random(-1000, 1000);
    for (int i = 0; i < 100; i++) put(fr[i], (i == 0), 1'b1);
    rst = 1'b0;
    #2;
    check("midrst_dout",  64'(bus.dataOut), 64'd0);
    check("midrst_valid", 64'(bus.dataOutValid), 64'd0);
    check("midrst_ready", 64'(bus.corrInReady), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    last_commit = '0;
    fill_random(-1000, 1000);
    send_frame(1'b1, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lag_peak_finder.md
LAG_PEAK_FINDER -- requirements
Module: lag_peak_finder

Interface
REQ-001 The block SHALL have parameter NUM_SLAVES, default 4, giving the number of SPI channels (one correlation curve each).
REQ-002 The block SHALL have parameter MAX_LAGS, default 17, giving the maximum correlation delay in samples; legal range 2..31.
REQ-003 The block SHALL have parameter CORR_BITS, default 32, giving the signed correlation sample width.
REQ-004 The block SHALL derive LAG_BITS = $clog2(2*MAX_LAGS) (6 at default) and NUM_LAGS = 2*MAX_LAGS-1 (33 at default) as local constants.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port corrIn, input, CORR_BITS: the signed correlation sample.
REQ-008 The block SHALL have port corrInValid, input, 1 bit: corrIn is valid this cycle.
REQ-009 The block SHALL have port corrInStart, input, 1 bit: marks the current sample as channel 0, lag 0, i.e. the frame start.
REQ-010 The block SHALL have port corrInReady, output, 1 bit: a sample is accepted only when corrInValid && corrInReady.
REQ-011 The block SHALL have port dataOut, output, NUM_SLAVES*LAG_BITS (24 at default): the packed per-channel peak lag index, with channel k in bits [k*LAG_BITS +: LAG_BITS].
REQ-012 The block SHALL have port dataOutValid, output, 1 bit: dataOut holds a completed frame.

Function
REQ-013 The block SHALL receive a frame as NUM_SLAVES*NUM_LAGS accepted samples ordered channel-major, with lag index 0..NUM_LAGS-1 per channel; lag index MAX_LAGS-1 represents zero delay.
REQ-014 The block SHALL implement an FSM with states IDLE, ACCUM and COMMIT.
REQ-015 In IDLE, the block SHALL discard accepted samples without corrInStart, and on an accepted sample with corrInStart it SHALL load that sample as channel 0, lag 0 and go to ACCUM.
REQ-016 In ACCUM, each accepted sample SHALL advance the lag counter, which wraps at NUM_LAGS-1 to 0 and then increments the channel counter; cycles without an accepted sample SHALL leave all state unchanged.
REQ-017 Per channel, the block SHALL keep a running max and argmax: lag 0 always loads; a later sample replaces them only if strictly greater, so ties keep the earliest lag.
REQ-018 Comparison SHALL be signed, at full CORR_BITS width, with no truncation.
REQ-019 The block SHALL write each channel's argmax into a working register when that channel's last lag (NUM_LAGS-1) is accepted, including the last sample's own contribution.
REQ-020 When channel NUM_SLAVES-1, lag NUM_LAGS-1 is accepted, the FSM SHALL go to COMMIT.
REQ-021 COMMIT SHALL last exactly one cycle, with corrInReady=0; at its end the working registers SHALL be copied to dataOut atomically, dataOutValid SHALL be set to 1, and the FSM SHALL return to IDLE.
REQ-022 Latency SHALL be: last sample accepted at edge N, COMMIT during cycle N to N+1, new dataOut visible after edge N+1.
REQ-023 corrInReady SHALL be 1 in IDLE and ACCUM.
REQ-024 An accepted corrInStart in ACCUM SHALL abort the frame: counters and working registers restart with this sample as channel 0, lag 0, and dataOut and dataOutValid SHALL remain unchanged.
REQ-025 dataOut SHALL change only at COMMIT; partial frames SHALL never be visible.
REQ-026 dataOutValid SHALL be sticky: once set it SHALL stay 1 until reset.

Reset
REQ-027 When rst=0, the block SHALL immediately set the FSM to IDLE, clear the counters, running max and working registers, and drive dataOut=0 and dataOutValid=0; corrInReady SHALL be 1 after reset.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; no COMMIT occurs.
REQ-029 Reset release SHALL be synchronised externally; the block SHALL rely on that synchronisation.

Configuration
REQ-030 With LAG_PEAK_FINDER_ABS_EN defined, the block SHALL compare |corrIn| instead of the signed value; |most-negative| SHALL saturate to the most-positive value, and ties are broken as in REQ-017.
REQ-031 Without LAG_PEAK_FINDER_ABS_EN, the block SHALL use signed comparison as in REQ-018 and SHALL contain no absolute-value logic.

Verification
REQ-032 Defaults, ch k peak = 1000 at lag 4k+2 and all other samples 0 -> dataOut = {6'd14, 6'd10, 6'd6, 6'd2}, dataOutValid=1 after edge N+1, corrInReady=0 during COMMIT.
REQ-033 Ties: ch0 lags 5 and 20 both 77 and others -5 -> ch0 field = 5; all-equal channel -> field = 0.
REQ-034 Negative curve: ch1 all negative with max -3 at lag 30 -> field = 30. With ABS_EN and a -2^31 sample at lag 7 -> field = 7.
REQ-035 Abort: frame 1 commits 0x0820C4; frame 2 restarts with corrInStart at sample 50, then completes -> dataOut holds 0x0820C4 until the restarted frame commits, and only its values appear.
REQ-036 Stall and reset: random corrInValid gaps (30% duty) -> same result as the gapless run; rst=0 at sample 100 -> dataOut=0 and dataOutValid=0 immediately, and the next full frame commits correctly.
